// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Shares one 256K x 16 async SRAM between a high-priority video
//             read port and a byte-enabled CPU read/write port, with a
//             bounded-wait guarantee for the CPU.
//  Options  : define SRAM_ARB_STATS_EN for per-port completed-access counters.
//  Revision : 1.0  initial release
// ============================================================================
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_WAIT      = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iV_REQ,
    input  logic [17:0] iV_ADDR,
    output logic        oV_ACK,
    output logic [15:0] oV_RDATA,
    input  logic        iC_REQ,
    input  logic        iC_WE,
    input  logic [17:0] iC_ADDR,
    input  logic [15:0] iC_WDATA,
    input  logic [1:0]  iC_BE,
    output logic        oC_ACK,
    output logic [15:0] oC_RDATA,
    output logic        oBUSY,
`ifdef SRAM_ARB_STATS_EN
    input  logic        iSTAT_CLR,
    output logic [15:0] oV_GRANTS,
    output logic [15:0] oC_GRANTS,
`endif
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [3:0] c_LAST     = 4'(ACCESS_CYCLES - 1);
    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [7:0]  r_starve;
    logic [17:0] r_addr;
    logic [15:0] r_wdata;
    logic [1:0]  r_be;
    logic        r_we;
    logic        r_sel_cpu;
    logic        w_gnt_v;
    logic        w_gnt_c;
    logic        w_dq_oe;

    // Video wins ties unless the CPU has already waited MAX_WAIT video grants.
    assign w_gnt_v = iV_REQ && !(iC_REQ && (r_starve == c_MAX_WAIT));
    assign w_gnt_c = iC_REQ && !w_gnt_v;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 4'd0;
            r_starve  <= 8'd0;
            r_addr    <= 18'd0;
            r_wdata   <= 16'd0;
            r_be      <= 2'b00;
            r_we      <= 1'b0;
            r_sel_cpu <= 1'b0;
            oV_RDATA  <= 16'd0;
            oC_RDATA  <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (!iC_REQ || w_gnt_c) begin
                        r_starve <= 8'd0;
                    end else if (w_gnt_v && (r_starve != c_MAX_WAIT)) begin
                        r_starve <= r_starve + 8'd1;
                    end
                    if (w_gnt_v || w_gnt_c) begin
                        r_addr    <= w_gnt_c ? iC_ADDR : iV_ADDR;
                        r_we      <= w_gnt_c && iC_WE;
                        r_wdata   <= iC_WDATA;
                        r_be      <= iC_BE;
                        r_sel_cpu <= w_gnt_c;
                        r_cnt     <= 4'd0;
                    end
                end
                ST_ACCESS: begin
                    r_cnt <= r_cnt + 4'd1;
                    if ((r_cnt == c_LAST) && !r_we) begin
                        if (r_sel_cpu) begin
                            oC_RDATA <= SRAM_DQ;
                        end else begin
                            oV_RDATA <= SRAM_DQ;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        SRAM_CE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        SRAM_WE_N   = 1'b1;
        SRAM_UB_N   = 1'b1;
        SRAM_LB_N   = 1'b1;
        w_dq_oe     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iV_REQ || iC_REQ) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                SRAM_CE_N = 1'b0;
                if (r_we) begin
                    SRAM_WE_N = 1'b0;
                    SRAM_UB_N = ~r_be[1];
                    SRAM_LB_N = ~r_be[0];
                    w_dq_oe   = 1'b1;
                end else begin
                    SRAM_OE_N = 1'b0;
                    SRAM_UB_N = 1'b0;
                    SRAM_LB_N = 1'b0;
                end
                if (r_cnt == c_LAST) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                // Write data stays on the bus one cycle past WE_N for hold time.
                w_dq_oe     = r_we;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign SRAM_ADDR = r_addr;
    assign SRAM_DQ   = w_dq_oe ? r_wdata : 16'bz;
    assign oV_ACK    = (r_state == ST_ACK) && !r_sel_cpu;
    assign oC_ACK    = (r_state == ST_ACK) && r_sel_cpu;
    assign oBUSY     = (r_state != ST_IDLE);

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] r_v_grants;
    logic [15:0] r_c_grants;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_v_grants <= 16'd0;
            r_c_grants <= 16'd0;
        end else if (iSTAT_CLR) begin
            r_v_grants <= 16'd0;
            r_c_grants <= 16'd0;
        end else begin
            if (oV_ACK && (r_v_grants != 16'hFFFF)) begin
                r_v_grants <= r_v_grants + 16'd1;
            end
            if (oC_ACK && (r_c_grants != 16'hFFFF)) begin
                r_c_grants <= r_c_grants + 16'd1;
            end
        end
    end

    assign oV_GRANTS = r_v_grants;
    assign oC_GRANTS = r_c_grants;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arbiter
//  Purpose  : Self-checking bench for sram_arbiter with a behavioural SRAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

    localparam logic [17:0] c_VADDR = 18'h2A5A5;

    logic        clk;
    logic        rst;
    logic        v_req;
    logic [17:0] v_addr;
    logic        v_ack;
    logic [15:0] v_rdata;
    logic        c_req;
    logic        c_we;
    logic [17:0] c_addr;
    logic [15:0] c_wdata;
    logic [1:0]  c_be;
    logic        c_ack;
    logic [15:0] c_rdata;
    logic        busy;
    logic [17:0] sram_addr;
    tri1  [15:0] sram_dq;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;
`ifdef SRAM_ARB_STATS_EN
    logic        stat_clr;
    logic [15:0] v_grants;
    logic [15:0] c_grants;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] v_exp[$];
    logic [15:0] c_exp[$];

    // Snapshots of one access taken by do_access
    int          s_lat;
    bit          s_timeout;
    logic [17:0] s_addr;
    logic        s_oe_n, s_we_n, s_ub_n, s_lb_n;
    logic [15:0] s_dq;
    logic [4:0]  s_ack_ctrl;
    logic [15:0] s_ack_dq;

    sram_arbiter #(.ACCESS_CYCLES(2), .MAX_WAIT(4)) dut (
        .iCLK(clk), .iRST(rst),
        .iV_REQ(v_req), .iV_ADDR(v_addr), .oV_ACK(v_ack), .oV_RDATA(v_rdata),
        .iC_REQ(c_req), .iC_WE(c_we), .iC_ADDR(c_addr), .iC_WDATA(c_wdata),
        .iC_BE(c_be), .oC_ACK(c_ack), .oC_RDATA(c_rdata), .oBUSY(busy),
`ifdef SRAM_ARB_STATS_EN
        .iSTAT_CLR(stat_clr), .oV_GRANTS(v_grants), .oC_GRANTS(c_grants),
`endif
        .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq), .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    always #5 clk = ~clk;

    // Behavioural async SRAM; the video word is preloaded while in reset.
    logic [15:0] mem [0:262143];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (rst) begin
            mem[c_VADDR] <= 16'hA5C3;
        end else if (!ce_n && !we_n) begin
            if (!ub_n) mem[sram_addr][15:8] <= sram_dq[15:8];
            if (!lb_n) mem[sram_addr][7:0]  <= sram_dq[7:0];
        end
    end

    task automatic do_access(input bit cpu, input bit we, input logic [17:0] a,
                             input logic [15:0] d, input logic [1:0] be);
        bit seen;
        seen = 0;
        @(negedge clk);
        if (cpu) begin
            c_req = 1; c_we = we; c_addr = a; c_wdata = d; c_be = be;
        end else begin
            v_req = 1; v_addr = a;
        end
        s_lat = 0; s_timeout = 1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (!ce_n && !seen) begin
                seen = 1; s_addr = sram_addr; s_oe_n = oe_n; s_we_n = we_n;
                s_ub_n = ub_n; s_lb_n = lb_n; s_dq = sram_dq;
            end
            if (cpu ? c_ack : v_ack) begin
                s_lat = k; s_timeout = 0;
                s_ack_ctrl = {ce_n, oe_n, we_n, ub_n, lb_n};
                s_ack_dq = sram_dq;
                break;
            end
        end
        if (cpu) c_req = 0; else v_req = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111) begin n_bad++; $display("FAIL rst_ctrl: got %b want 11111", {ce_n, oe_n, we_n, ub_n, lb_n}); end
        n_cmp++; if (sram_addr !== 18'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
        n_cmp++; if (sram_dq !== 16'hFFFF) begin n_bad++; $display("FAIL rst_dq: got %h want released", sram_dq); end
        n_cmp++; if ({v_ack, c_ack, busy} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {v_ack, c_ack, busy}); end
        n_cmp++; if ({v_rdata, c_rdata} !== 32'd0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", {v_rdata, c_rdata}); end
        rst = 0;
    endtask

    task automatic test_write_read();
        logic [15:0] e;
        do_access(1, 1, 18'h00123, 16'hBEEF, 2'b11);
        n_cmp++; if (s_timeout || s_lat != 3) begin n_bad++; $display("FAIL wr_latency: got %0d want 3", s_lat); end
        n_cmp++; if ({s_addr, s_oe_n, s_we_n, s_dq} !== {18'h00123, 1'b1, 1'b0, 16'hBEEF}) begin n_bad++; $display("FAIL wr_drive: got %h/%b%b/%h want 00123/10/beef", s_addr, s_oe_n, s_we_n, s_dq); end
        n_cmp++; if (s_ack_ctrl !== 5'b11111 || s_ack_dq !== 16'hBEEF) begin n_bad++; $display("FAIL wr_ack_phase: got %b/%h want 11111/beef", s_ack_ctrl, s_ack_dq); end
        n_cmp++; if (c_rdata !== 16'h0000) begin n_bad++; $display("FAIL wr_keeps_rdata: got %h want 0000", c_rdata); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || sram_dq !== 16'hFFFF) begin n_bad++; $display("FAIL turnaround: got busy %b dq %h want 0/released", busy, sram_dq); end
        c_exp.push_back(16'hBEEF);
        do_access(1, 0, 18'h00123, 16'h0000, 2'b00);
        e = c_exp.pop_front();
        n_cmp++; if (s_timeout || c_rdata !== e) begin n_bad++; $display("FAIL rd_data: got %h want %h", c_rdata, e); end
        n_cmp++; if ({s_oe_n, s_we_n, s_ub_n, s_lb_n} !== 4'b0100) begin n_bad++; $display("FAIL rd_ctrl: got %b want 0100", {s_oe_n, s_we_n, s_ub_n, s_lb_n}); end
        n_cmp++; if (v_rdata !== 16'h0000) begin n_bad++; $display("FAIL rd_other_port: got %h want 0000", v_rdata); end
    endtask

    task automatic test_byte_enable();
        logic [15:0] e;
        do_access(1, 1, 18'h00123, 16'h12AB, 2'b01);
        n_cmp++; if ({s_ub_n, s_lb_n} !== 2'b10) begin n_bad++; $display("FAIL be_strobes: got %b want 10", {s_ub_n, s_lb_n}); end
        n_cmp++; if (c_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL be_keeps_rdata: got %h want beef", c_rdata); end
        c_exp.push_back(16'hBEAB);
        do_access(1, 0, 18'h00123, 16'h0000, 2'b00);
        e = c_exp.pop_front();
        n_cmp++; if (s_timeout || c_rdata !== e) begin n_bad++; $display("FAIL be_readback: got %h want %h", c_rdata, e); end
    endtask

    task automatic test_priority();
        int v_cyc, c_cyc;
        logic [15:0] e;
        v_cyc = 0; c_cyc = 0;
        v_exp.push_back(16'hA5C3);
        c_exp.push_back(16'hBEAB);
        @(negedge clk);
        v_req = 1; v_addr = c_VADDR; c_req = 1; c_we = 0; c_addr = 18'h00123;
        for (int k = 1; k <= 40 && (v_cyc == 0 || c_cyc == 0); k++) begin
            @(negedge clk);
            if (v_ack && v_exp.size() > 0) begin
                v_cyc = k; v_req = 0; e = v_exp.pop_front();
                n_cmp++; if (v_rdata !== e) begin n_bad++; $display("FAIL pri_vdata: got %h want %h", v_rdata, e); end
            end
            if (c_ack && c_exp.size() > 0) begin
                c_cyc = k; c_req = 0; e = c_exp.pop_front();
                n_cmp++; if (c_rdata !== e) begin n_bad++; $display("FAIL pri_cdata: got %h want %h", c_rdata, e); end
            end
        end
        v_req = 0; c_req = 0;
        n_cmp++; if (v_cyc != 3 || c_cyc != 7) begin n_bad++; $display("FAIL pri_order: got v@%0d c@%0d want v@3 c@7", v_cyc, c_cyc); end
    endtask

    task automatic test_starvation();
        logic [5:0]  seq;
        logic [15:0] e;
        int n;
        n = 0; seq = '0;
        repeat (5) v_exp.push_back(16'hA5C3);
        c_exp.push_back(16'hBEAB);
        @(negedge clk);
        v_req = 1; v_addr = c_VADDR; c_req = 1; c_we = 0; c_addr = 18'h00123;
        for (int k = 0; k < 100 && n < 6; k++) begin
            @(negedge clk);
            if (c_ack || v_ack) begin
                seq[n] = c_ack; n++;
                if (c_ack) c_req = 0;
                if (c_ack ? (c_exp.size() == 0) : (v_exp.size() == 0)) begin
                    n_cmp++; n_bad++; $display("FAIL starve_extra_ack: got ack #%0d want none", n);
                end else begin
                    e = c_ack ? c_exp.pop_front() : v_exp.pop_front();
                    n_cmp++; if ((c_ack ? c_rdata : v_rdata) !== e) begin n_bad++; $display("FAIL starve_data: got %h want %h", c_ack ? c_rdata : v_rdata, e); end
                end
            end
        end
        v_req = 0; c_req = 0;
        n_cmp++; if (n != 6 || seq !== 6'b010000) begin n_bad++; $display("FAIL starve_seq: got %0d acks %b want 6 acks 010000", n, seq); end
        n_cmp++; if (v_exp.size() != 0 || c_exp.size() != 0) begin n_bad++; $display("FAIL starve_pending: got %0d/%0d want 0/0", v_exp.size(), c_exp.size()); end
        v_exp.delete(); c_exp.delete();
    endtask

    task automatic test_reset_mid_write();
        bit seen, ackd;
        seen = 0; ackd = 0;
        @(negedge clk);
        c_req = 1; c_we = 1; c_addr = 18'h3FFFF; c_wdata = 16'h5555; c_be = 2'b11;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (!we_n) seen = 1;
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL mid_wr_start: got no WE_N low want WE_N low"); end
        rst = 1; c_req = 0;
        #1;
        n_cmp++; if ({ce_n, we_n} !== 2'b11 || sram_dq !== 16'hFFFF) begin n_bad++; $display("FAIL mid_wr_rst: got ce/we %b dq %h want 11/released", {ce_n, we_n}, sram_dq); end
        n_cmp++; if (busy !== 1'b0 || sram_addr !== 18'd0) begin n_bad++; $display("FAIL mid_wr_state: got busy %b addr %h want 0/0", busy, sram_addr); end
        repeat (2) begin @(negedge clk); ackd |= c_ack; end
        rst = 0;
        repeat (6) begin @(negedge clk); ackd |= c_ack; end
        n_cmp++; if (ackd) begin n_bad++; $display("FAIL mid_wr_ack: got oC_ACK want none"); end
    endtask

`ifdef SRAM_ARB_STATS_EN
    task automatic test_stats();
        n_cmp++; if ({v_grants, c_grants} !== 32'd0) begin n_bad++; $display("FAIL stats_reset: got %0d/%0d want 0/0", v_grants, c_grants); end
        repeat (3) do_access(0, 0, c_VADDR, 16'h0000, 2'b00);
        repeat (2) do_access(1, 1, 18'h00200, 16'h7777, 2'b11);
        @(negedge clk);
        n_cmp++; if (v_grants !== 16'd3 || c_grants !== 16'd2) begin n_bad++; $display("FAIL stats_count: got %0d/%0d want 3/2", v_grants, c_grants); end
        stat_clr = 1;
        @(negedge clk);
        stat_clr = 0;
        n_cmp++; if ({v_grants, c_grants} !== 32'd0) begin n_bad++; $display("FAIL stats_clear: got %0d/%0d want 0/0", v_grants, c_grants); end
    endtask
`endif

    initial begin
        clk = 0; rst = 1;
        v_req = 0; v_addr = '0;
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0; c_be = '0;
`ifdef SRAM_ARB_STATS_EN
        stat_clr = 0;
`endif
        test_reset();
        test_write_read();
        test_byte_enable();
        test_priority();
        test_starvation();
        test_reset_mid_write();
`ifdef SRAM_ARB_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
